mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multi-cycle control sequencer for the MIPS core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the datapath enables, mux selects and alu_control, and handshakes with a shared instruction/data memory port. It replaces per-instruction static decoding with a state machine, so one ALU and one memory port serve every phase of an instruction.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before bus-error trap (>=1)
RETIRE_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until next FETCH
func  in  6  IR[5:0]
alu_zero  in  1  ALU result==0, valid in EXEC
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write strobe, valid with mem_req
mem_addr_sel  out  1  0=PC, 1=ALU result register
ir_write  out  1  load IR from memory read data
pc_write  out  1  update PC
pc_src  out  2  00=PC+4, 01=branch target, 10=jump target
alu_src_b  out  2  00=rt, 01=constant 4, 10=sign-extended imm
alu_control  out  6  00_0000 none, 10_0001 ADDU, 10_0011 SUBU, 10_0100 AND, 10_0101 OR, 11_1111 idle
reg_write  out  1  register file write enable
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALU result, 1=memory data
trap  out  2  00 none, 01 illegal instruction, 10 bus error (sticky)
retired  out  RETIRE_W  count of completed instructions

Behaviour:
- Reset (async assert, sync release): state=FETCH, timeout counter=0, trap=00, retired=0. All strobes 0. alu_control=11_1111. Selects 0.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Strobes are decoded from state and registered fields. pc_write and ir_write are Mealy on mem_ready or alu_zero as noted.
- FETCH: mem_req=1, mem_we=0, mem_addr_sel=0. On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Otherwise stay.
- DECODE: check opcode/func.
  - R-type (opcode 000000) with func in {100001, 100011, 100100, 100101} goes to EXEC.
  - ADDIU 001001, LW 100011, SW 101011 and BEQ 000100 go to EXEC.
  - J 000010: pc_write=1, pc_src=10, retired+1, then FETCH.
  - Anything else: trap=01, then TRAP.
- EXEC:
  - R-type: alu_src_b=00, alu_control=func, then WB.
  - ADDIU/LW/SW: alu_src_b=10, alu_control=10_0001. ADDIU goes to WB; LW/SW go to MEM.
  - BEQ: alu_src_b=00, alu_control=10_0011. pc_write=alu_zero, pc_src=01. retired+1, then FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for SW only.
  - On mem_ready: SW gets retired+1 and goes to FETCH; LW goes to WB.
  - Without mem_ready: stay.
- WB: reg_write=1 for exactly one cycle. reg_dst=1 for R-type, else 0. mem_to_reg=1 for LW only. retired+1, then FETCH.
- Latency with mem_ready tied 1: J 2, BEQ 3, R-type/ADDIU/SW 4, LW 5 cycles.
- Timeout:
  - Counter increments each cycle in FETCH/MEM while mem_ready=0.
  - Counter clears on mem_ready or on leaving the state.
  - When it reaches MEM_TIMEOUT with mem_ready still 0: trap=10, go to TRAP, no strobe that cycle.
  - mem_ready in the same cycle wins over timeout.
- TRAP: all strobes 0, alu_control=11_1111, trap held, retired frozen. Only reset exits.
- retired wraps modulo 2^RETIRE_W. It increments at most once per instruction.
- Reset mid-instruction: immediate return to reset values. No partial reg_write or mem_we may appear after rst_n falls.
- mem_we never asserts without mem_req. reg_write and pc_write are never both 1 in the same cycle.

Test Plan:
- Reset, then ADDU (op 000000, func 100001) with mem_ready=1:
  - FETCH→DECODE→EXEC→WB→FETCH.
  - alu_control=10_0001 in EXEC; reg_write=1, reg_dst=1 in WB.
  - retired=1 after 4 cycles.
- LW (100011) with mem_ready low for 3 cycles in MEM:
  - mem_req held 4 cycles with mem_addr_sel=1, mem_we=0.
  - WB has mem_to_reg=1, reg_dst=0; 8 cycles total.
- BEQ with alu_zero=1:
  - pc_write=1, pc_src=01 in EXEC.
  - Repeat with alu_zero=0: pc_write=0. Both runs increment retired.
- J then SW:
  - J gives pc_src=10, 2 cycles.
  - SW gives mem_we=1 with mem_req in MEM, never reg_write. retired=2.
- Illegal opcode 111111, and R-type func 000000:
  - trap=01 and stuck in TRAP for 20+ cycles.
  - rst_n pulse returns to FETCH with trap=00.
- MEM_TIMEOUT=4 with mem_ready=0 in FETCH:
  - trap=10 after 4 waiting cycles.
  - Separate run with mem_ready on cycle 4: no trap.
- Assert rst_n=0 during WB of an ADDU: reg_write drops asynchronously and retired=0.

Source files
------------

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control sequencer: walks each instruction through FETCH, DECODE, EXEC, MEM
// and WB, sharing one ALU and one memory port, with illegal-instruction and bus-timeout traps.
module mips_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_addr_sel,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_src_b,
    output logic [5:0]          alu_control,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic [1:0]          trap,
    output logic [RETIRE_W-1:0] retired
);

    localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

    localparam logic [5:0] AluNone = 6'b00_0000;
    localparam logic [5:0] AluAddu = 6'b10_0001;
    localparam logic [5:0] AluSubu = 6'b10_0011;
    localparam logic [5:0] AluIdle = 6'b11_1111;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
    typedef enum logic [2:0] {OpR, OpAddiu, OpLw, OpSw, OpBeq} op_e;

    state_e                state_q;
    op_e                   op_q;
    logic [TW-1:0]         tcnt_q;
    logic [1:0]            trap_q;
    logic [RETIRE_W-1:0]   retired_q;

    logic dec_ok;
    logic dec_jump;
    op_e  dec_op;
    logic waiting;
    logic timed_out;

    always_comb begin
        dec_ok   = 1'b0;
        dec_jump = 1'b0;
        dec_op   = OpR;
        case (opcode)
            6'b000000: begin
                dec_op = OpR;
                dec_ok = (func == 6'b100001) || (func == 6'b100011) ||
                         (func == 6'b100100) || (func == 6'b100101);
            end
            6'b001001: begin dec_op = OpAddiu; dec_ok = 1'b1; end
            6'b100011: begin dec_op = OpLw;    dec_ok = 1'b1; end
            6'b101011: begin dec_op = OpSw;    dec_ok = 1'b1; end
            6'b000100: begin dec_op = OpBeq;   dec_ok = 1'b1; end
            6'b000010: dec_jump = 1'b1;
            default:   dec_ok = 1'b0;
        endcase
    end

    // A ready in the final allowed cycle beats the timeout.
    assign waiting   = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    assign timed_out = waiting && (tcnt_q == TMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            op_q      <= OpR;
            tcnt_q    <= '0;
            trap_q    <= 2'b00;
            retired_q <= '0;
        end else begin
            tcnt_q <= (waiting && !timed_out) ? tcnt_q + 1'b1 : '0;
            case (state_q)
                StFetch: begin
                    if (mem_ready) begin
                        state_q <= StDecode;
                    end else if (timed_out) begin
                        trap_q  <= 2'b10;
                        state_q <= StTrap;
                    end
                end
                StDecode: begin
                    if (dec_jump) begin
                        retired_q <= retired_q + 1'b1;
                        state_q   <= StFetch;
                    end else if (dec_ok) begin
                        op_q    <= dec_op;
                        state_q <= StExec;
                    end else begin
                        trap_q  <= 2'b01;
                        state_q <= StTrap;
                    end
                end
                StExec: begin
                    case (op_q)
                        OpR, OpAddiu: state_q <= StWb;
                        OpLw, OpSw:   state_q <= StMem;
                        default: begin
                            retired_q <= retired_q + 1'b1;
                            state_q   <= StFetch;
                        end
                    endcase
                end
                StMem: begin
                    if (mem_ready) begin
                        if (op_q == OpSw) begin
                            retired_q <= retired_q + 1'b1;
                            state_q   <= StFetch;
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (timed_out) begin
                        trap_q  <= 2'b10;
                        state_q <= StTrap;
                    end
                end
                StWb: begin
                    retired_q <= retired_q + 1'b1;
                    state_q   <= StFetch;
                end
                StTrap:  state_q <= StTrap;
                default: state_q <= StTrap;
            endcase
        end
    end

    // Strobes are gated by rst_n so they drop the moment reset asserts, not at the next edge.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_b    = 2'b00;
        alu_control  = AluIdle;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        if (rst_n) begin
            alu_control = (state_q == StTrap) ? AluIdle : AluNone;
            case (state_q)
                StFetch: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                StDecode: begin
                    if (dec_jump) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                end
                StExec: begin
                    case (op_q)
                        OpR: alu_control = func;
                        OpAddiu, OpLw, OpSw: begin
                            alu_src_b   = 2'b10;
                            alu_control = AluAddu;
                        end
                        default: begin
                            alu_control = AluSubu;
                            pc_write    = alu_zero;
                            pc_src      = 2'b01;
                        end
                    endcase
                end
                StMem: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (op_q == OpSw);
                end
                StWb: begin
                    reg_write  = 1'b1;
                    reg_dst    = (op_q == OpR);
                    mem_to_reg = (op_q == OpLw);
                end
                default: alu_control = AluIdle;
            endcase
        end
    end

    assign trap    = trap_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: each driven cycle queues its hand-computed output vector,
// and a negedge monitor pops and compares it against the DUT.
module tb_mips_mc_ctrl;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        mem_addr_sel;
        logic        ir_write;
        logic        pc_write;
        logic [1:0]  pc_src;
        logic [1:0]  alu_src_b;
        logic [5:0]  alu_control;
        logic        reg_write;
        logic        reg_dst;
        logic        mem_to_reg;
        logic [1:0]  trap;
        logic [31:0] retired;
    } outs_t;

    typedef struct {
        outs_t exp;
        string name;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  func = '0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_b, trap;
    logic [5:0]  alu_control;
    logic        reg_write, reg_dst, mem_to_reg;
    logic [31:0] retired;

    outs_t       got;
    ent_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;
    logic [31:0] ret = '0;

    mips_mc_ctrl #(.MEM_TIMEOUT(4), .RETIRE_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    assign got = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_b,
                  alu_control, reg_write, reg_dst, mem_to_reg, trap, retired};

    // Expected output vectors, one builder per kind of cycle.
    function automatic outs_t base(input logic [31:0] r);
        outs_t o = '0;
        o.retired = r;
        return o;
    endfunction
    function automatic outs_t f_fetch(input logic rdy, input logic [31:0] r);
        outs_t o = base(r);
        o.mem_req = 1'b1; o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic outs_t f_jump(input logic [31:0] r);
        outs_t o = base(r);
        o.pc_write = 1'b1; o.pc_src = 2'b10;
        return o;
    endfunction
    function automatic outs_t f_exr(input logic [5:0] fn, input logic [31:0] r);
        outs_t o = base(r);
        o.alu_control = fn;
        return o;
    endfunction
    function automatic outs_t f_exi(input logic [31:0] r);
        outs_t o = base(r);
        o.alu_src_b = 2'b10; o.alu_control = 6'b10_0001;
        return o;
    endfunction
    function automatic outs_t f_beq(input logic z, input logic [31:0] r);
        outs_t o = base(r);
        o.alu_control = 6'b10_0011; o.pc_write = z; o.pc_src = 2'b01;
        return o;
    endfunction
    function automatic outs_t f_mem(input logic we, input logic [31:0] r);
        outs_t o = base(r);
        o.mem_req = 1'b1; o.mem_addr_sel = 1'b1; o.mem_we = we;
        return o;
    endfunction
    function automatic outs_t f_wb(input logic dst, input logic m2r, input logic [31:0] r);
        outs_t o = base(r);
        o.reg_write = 1'b1; o.reg_dst = dst; o.mem_to_reg = m2r;
        return o;
    endfunction
    function automatic outs_t f_trap(input logic [1:0] code, input logic [31:0] r);
        outs_t o = base(r);
        o.alu_control = 6'b11_1111; o.trap = code;
        return o;
    endfunction

    task automatic step(input logic rdy, input logic z, input outs_t e, input string nm);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        opcode = cur_op;
        func = cur_fn;
        mem_ready = rdy;
        alu_zero = z;
        sb.push_back('{exp: e, name: nm});
    endtask

    task automatic hold_reset(input string nm);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        sb.push_back('{exp: f_trap(2'b00, 32'd0), name: nm});
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        cur_op = op;
        cur_fn = fn;
    endtask

    always @(negedge clk) begin
        ent_t e;
        checks++;
        if (mem_we && !mem_req) begin
            errors++;
            $display("FAIL we_without_req: mem_we=%b mem_req=%b required mem_we=0", mem_we, mem_req);
        end
        checks++;
        if (reg_write && pc_write) begin
            errors++;
            $display("FAIL regw_pcw_overlap: reg_write=%b pc_write=%b required not both",
                     reg_write, pc_write);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h required %h at %0t", e.name, got, e.exp, $time);
            end
        end
    end

    initial begin
        hold_reset("reset0");
        hold_reset("reset1");

        // ADDU, then LW with three wait cycles in MEM
        set_ir(6'b000000, 6'b100001);
        step(1, 0, f_fetch(1, ret), "addu_fetch");
        step(1, 0, base(ret), "addu_decode");
        step(1, 0, f_exr(6'b100001, ret), "addu_exec");
        step(1, 0, f_wb(1, 0, ret), "addu_wb");
        ret++;
        set_ir(6'b100011, 6'b000000);
        step(1, 0, f_fetch(1, ret), "lw_fetch");
        step(1, 0, base(ret), "lw_decode");
        step(1, 0, f_exi(ret), "lw_exec");
        for (int i = 0; i < 3; i++) step(0, 0, f_mem(0, ret), "lw_mem_wait");
        step(1, 0, f_mem(0, ret), "lw_mem_ready");
        step(1, 0, f_wb(0, 1, ret), "lw_wb");
        ret++;

        // BEQ taken and not taken
        set_ir(6'b000100, 6'b000000);
        step(1, 0, f_fetch(1, ret), "beq1_fetch");
        step(1, 0, base(ret), "beq1_decode");
        step(1, 1, f_beq(1, ret), "beq1_exec_taken");
        ret++;
        step(1, 0, f_fetch(1, ret), "beq0_fetch");
        step(1, 0, base(ret), "beq0_decode");
        step(1, 0, f_beq(0, ret), "beq0_exec_not_taken");
        ret++;

        // J then SW, then OR and ADDIU
        set_ir(6'b000010, 6'b000000);
        step(1, 0, f_fetch(1, ret), "j_fetch");
        step(1, 0, f_jump(ret), "j_decode");
        ret++;
        set_ir(6'b101011, 6'b000000);
        step(1, 0, f_fetch(1, ret), "sw_fetch");
        step(1, 0, base(ret), "sw_decode");
        step(1, 0, f_exi(ret), "sw_exec");
        step(1, 0, f_mem(1, ret), "sw_mem");
        ret++;
        set_ir(6'b000000, 6'b100101);
        step(1, 0, f_fetch(1, ret), "or_fetch");
        step(1, 0, base(ret), "or_decode");
        step(1, 0, f_exr(6'b100101, ret), "or_exec");
        step(1, 0, f_wb(1, 0, ret), "or_wb");
        ret++;
        set_ir(6'b001001, 6'b000000);
        step(1, 0, f_fetch(1, ret), "addiu_fetch");
        step(1, 0, base(ret), "addiu_decode");
        step(1, 0, f_exi(ret), "addiu_exec");
        step(1, 0, f_wb(0, 0, ret), "addiu_wb");
        ret++;

        // Fetch ready on the last allowed cycle: no trap
        set_ir(6'b000000, 6'b100001);
        for (int i = 0; i < 3; i++) step(0, 0, f_fetch(0, ret), "tmo_edge_wait");
        step(1, 0, f_fetch(1, ret), "tmo_edge_ready");
        step(1, 0, base(ret), "tmo_edge_decode");
        step(1, 0, f_exr(6'b100001, ret), "tmo_edge_exec");
        step(1, 0, f_wb(1, 0, ret), "tmo_edge_wb");
        ret++;

        // Fetch never ready: bus-error trap, retired frozen
        for (int i = 0; i < 4; i++) step(0, 0, f_fetch(0, ret), "tmo_wait");
        for (int i = 0; i < 5; i++) step(1, 0, f_trap(2'b10, ret), "tmo_trap");
        hold_reset("tmo_reset");
        ret = '0;

        // Illegal opcode sticks in TRAP
        set_ir(6'b111111, 6'b000000);
        step(1, 0, f_fetch(1, ret), "ill_fetch");
        step(1, 0, base(ret), "ill_decode");
        for (int i = 0; i < 22; i++) step(1, 0, f_trap(2'b01, ret), "ill_trap");
        hold_reset("ill_reset");

        // R-type with unsupported func
        set_ir(6'b000000, 6'b000000);
        step(1, 0, f_fetch(1, ret), "rbad_fetch");
        step(1, 0, base(ret), "rbad_decode");
        for (int i = 0; i < 3; i++) step(1, 0, f_trap(2'b01, ret), "rbad_trap");
        hold_reset("rbad_reset");

        // Reset asserted mid-WB of an ADDU
        set_ir(6'b000000, 6'b100001);
        step(1, 0, f_fetch(1, ret), "rwb_fetch");
        step(1, 0, base(ret), "rwb_decode");
        step(1, 0, f_exr(6'b100001, ret), "rwb_exec");
        step(1, 0, f_wb(1, 0, ret), "rwb_wb");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        hold_reset("rwb_in_reset");
        step(0, 0, f_fetch(0, 32'd0), "rwb_after_release");

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
